time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have one clock and one reset: the clock is clk, and the reset is rst_n, asynchronous and active-low.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- time_cur  in  32  current time {mil[31:24], hour[23:16], min[15:8], sec[7:0]}, binary
- btn_mode  in  1  one-cycle pulse: enter edit, or advance to next field
- btn_inc  in  1  one-cycle pulse: increment selected field
- btn_dec  in  1  one-cycle pulse: decrement selected field
- btn_cancel  in  1  one-cycle pulse: abandon edit
- time_in  out  8  value bus to the time register
- set_mil, set_hour, set_minute, set_second  out  1 each  write strobes; the register captures on the rising edge
- editing  out  1  high in any EDIT_* state
- field  out  2  selected field: 0=mil, 1=hour, 2=min, 3=sec
- edit_val  out  8  value of the selected field, for display
- done  out  1  one-cycle pulse when commit completes
REQ-003 SHALL have no parameters; field limits are fixed: mil 0..1, hour 0..23, min 0..59, sec 0..59.

Function
REQ-004 SHALL implement states IDLE, EDIT_MIL, EDIT_HOUR, EDIT_MIN, EDIT_SEC and COMMIT; COMMIT has 8 sub-steps, counted by a 3-bit step counter.
REQ-005 IDLE: btn_mode SHALL load four 8-bit shadow registers from time_cur and go to EDIT_MIL.
- A loaded field above its limit is replaced by 0.
- All other buttons are ignored in IDLE.
REQ-006 EDIT_* state: btn_mode SHALL advance MIL->HOUR->MIN->SEC->COMMIT.
REQ-007 btn_inc SHALL add 1 to the selected shadow register; the value at its limit wraps to 0.
REQ-008 btn_dec SHALL subtract 1 from the selected shadow register; 0 wraps to the limit.
REQ-009 Button priority within a cycle SHALL be cancel > mode > inc/dec.
- btn_inc and btn_dec together produce no change.
- When mode wins, the inc/dec in that cycle is discarded.
REQ-010 btn_cancel in any EDIT_* state SHALL return to IDLE next cycle.
- No strobe is issued.
- Shadow contents are don't-care.
REQ-011 COMMIT SHALL write the fields in order mil, hour, minute, second, two cycles per field.
- Setup cycle: time_in = field value, strobe low.
- Strobe cycle: same time_in, that field's strobe high.
REQ-012 time_in SHALL be stable from the setup cycle through the falling edge of the strobe, so each rising strobe edge captures a settled value.
REQ-013 At most one set_* strobe SHALL be high in any cycle.
- Strobes are registered outputs, glitch-free.
- Strobes are high for exactly one cycle each.
REQ-014 After the set_second strobe cycle, the block SHALL pulse done for one cycle and return to IDLE.
- Total latency from the btn_mode that left EDIT_SEC to done is 9 cycles.
REQ-015 All buttons SHALL be ignored during COMMIT; commit cannot be aborted except by reset.
REQ-016 Outputs per state:
- editing is high only in EDIT_* states.
- field follows the EDIT state; it is 0 in IDLE.
- edit_val equals the selected shadow in EDIT_*; otherwise it is 0.
- time_in is 0 in IDLE and EDIT_*.

Reset
REQ-017 On rst_n low, the block SHALL immediately set, independent of clk:
- state = IDLE and step counter = 0
- shadows = 0
- time_in = 0, all set_* = 0, done = 0, editing = 0, field = 0
REQ-018 Reset asserted mid-COMMIT SHALL drop any high strobe at once; fields already strobed keep their new value in the time register.
REQ-019 After rst_n deasserts, the first button is honoured on the first rising clk edge at which rst_n is high.

Verification
REQ-020 Basic commit: time_cur=0x01_0C_1E_2D, press mode x5 with no edits -> strobes fire in order mil, hour, min, sec with time_in 0x01, 0x0C, 0x1E, 0x2D; done 9 cycles after the 5th mode; no strobe overlap.
REQ-021 Wrap: in EDIT_HOUR with value 23, inc -> 0; dec -> 23. In EDIT_MIN with 0, dec -> 59. In EDIT_MIL with 1, inc -> 0.
REQ-022 Clamp and priority:
- time_cur hour=0x30 loads hour=0.
- inc+dec in the same cycle leaves the value unchanged.
- mode+inc advances the field without incrementing.
REQ-023 Cancel: enter edit, inc minute, then cancel -> IDLE next cycle, zero strobes, editing=0.
REQ-024 Reset mid-commit: assert rst_n=0 during the set_hour strobe cycle -> set_hour falls immediately; no set_minute or set_second strobe; state IDLE.
REQ-025 Ignore during commit: btn_mode/btn_cancel pulses during COMMIT -> strobe sequence and done timing unchanged.

Source files
------------

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Button-driven editor for a 32-bit {mil,hour,min,sec} time
//               value. The current time is copied into four shadow
//               registers, edited field by field, and then written back
//               through an 8-bit bus with one write strobe per field.
//               Each field is written over two cycles: a setup cycle and
//               then a strobe cycle.
// Ports       : clk, rst_n (async, active-low)
//               time_cur[31:0]   current time {mil,hour,min,sec}, binary
//               btn_mode/inc/dec/cancel  one-cycle button pulses
//               time_in[7:0]     value bus to the time register
//               set_mil/hour/minute/second  registered write strobes
//               editing, field[1:0], edit_val[7:0]  display information
//               done             one-cycle pulse at the end of a commit
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] time_cur,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  output logic [7:0]  time_in,
  output logic        set_mil,
  output logic        set_hour,
  output logic        set_minute,
  output logic        set_second,
  output logic        editing,
  output logic [1:0]  field,
  output logic [7:0]  edit_val,
  output logic        done
);

  // State encoding: EDIT_* states are consecutive, so (state - 1) gives the
  // field index, and (EDIT_SEC + 1) gives COMMIT.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EDIT_MIL  = 3'd1;
  localparam logic [2:0] S_EDIT_HOUR = 3'd2;
  localparam logic [2:0] S_EDIT_MIN  = 3'd3;
  localparam logic [2:0] S_EDIT_SEC  = 3'd4;
  localparam logic [2:0] S_COMMIT    = 3'd5;

  // Highest legal value for each field.
  function automatic logic [7:0] field_limit(input logic [1:0] f);
    case (f)
      2'd0:    field_limit = 8'd1;
      2'd1:    field_limit = 8'd23;
      default: field_limit = 8'd59;
    endcase
  endfunction

  // A loaded value above its limit is replaced by 0.
  function automatic logic [7:0] clamp_load(input logic [7:0] v, input logic [1:0] f);
    clamp_load = (v > field_limit(f)) ? 8'd0 : v;
  endfunction

  logic [2:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_d [4];

  logic [7:0] time_in_q, time_in_d;
  logic [3:0] strobe_q, strobe_d;   // {mil, hour, minute, second}
  logic       done_q, done_d;

  logic       in_edit;
  logic [2:0] state_m1;
  logic [1:0] cur_f;

  assign in_edit  = (state_q >= S_EDIT_MIL) && (state_q <= S_EDIT_SEC);
  assign state_m1 = state_q - 3'd1;
  assign cur_f    = state_m1[1:0];

  // --------------------------------------------------------------------------
  // State register (also holds shadows and the registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'd0;
      time_in_q <= 8'd0;
      strobe_q  <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
      time_in_q <= time_in_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic (state, COMMIT step counter, shadow registers)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    for (int i = 0; i < 4; i++) shadow_d[i] = shadow_q[i];

    case (state_q)
      S_IDLE: begin
        if (btn_mode) begin
          shadow_d[0] = clamp_load(time_cur[31:24], 2'd0);
          shadow_d[1] = clamp_load(time_cur[23:16], 2'd1);
          shadow_d[2] = clamp_load(time_cur[15:8],  2'd2);
          shadow_d[3] = clamp_load(time_cur[7:0],   2'd3);
          state_d     = S_EDIT_MIL;
          step_d      = 3'd0;
        end
      end

      S_EDIT_MIL, S_EDIT_HOUR, S_EDIT_MIN, S_EDIT_SEC: begin
        // Priority: cancel > mode > inc/dec; inc and dec together cancel out.
        if (btn_cancel) begin
          state_d = S_IDLE;
        end else if (btn_mode) begin
          state_d = state_q + 3'd1;
          step_d  = 3'd0;
        end else if (btn_inc && !btn_dec) begin
          shadow_d[cur_f] = (shadow_q[cur_f] >= field_limit(cur_f)) ? 8'd0
                                                                    : shadow_q[cur_f] + 8'd1;
        end else if (btn_dec && !btn_inc) begin
          shadow_d[cur_f] = (shadow_q[cur_f] == 8'd0) ? field_limit(cur_f)
                                                      : shadow_q[cur_f] - 8'd1;
        end
      end

      S_COMMIT: begin
        // Buttons are deliberately not examined here.
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = S_IDLE;
          step_d  = 3'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Bus, strobes and done are computed from the *next*
  // state/step and registered, so they are glitch-free and line up with the
  // COMMIT step they belong to. Step s drives field s/2, and odd steps
  // are the strobe cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    time_in_d = 8'd0;
    strobe_d  = 4'd0;
    done_d    = 1'b0;
    if (state_d == S_COMMIT) begin
      time_in_d = shadow_d[step_d[2:1]];
      if (step_d[0]) strobe_d = 4'b1000 >> step_d[2:1];
    end
    if ((state_q == S_COMMIT) && (step_q == 3'd7)) done_d = 1'b1;

    editing  = in_edit;
    field    = in_edit ? cur_f : 2'd0;
    edit_val = in_edit ? shadow_q[cur_f] : 8'd0;
  end

  assign time_in    = time_in_q;
  assign set_mil    = strobe_q[3];
  assign set_hour   = strobe_q[2];
  assign set_minute = strobe_q[1];
  assign set_second = strobe_q[0];
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed self-checking bench for time_set_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] time_cur;
  logic        btn_mode, btn_inc, btn_dec, btn_cancel;
  logic [7:0]  time_in;
  logic        set_mil, set_hour, set_minute, set_second;
  logic        editing;
  logic [1:0]  field;
  logic [7:0]  edit_val;
  logic        done;

  logic [3:0]  strb;
  assign strb = {set_mil, set_hour, set_minute, set_second};

  int total = 0;
  int bad   = 0;

  time_set_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_cur   (time_cur),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .time_in    (time_in),
    .set_mil    (set_mil),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .editing    (editing),
    .field      (field),
    .edit_val   (edit_val),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d, input logic c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    tick();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
  endtask

  task automatic chk_edit(input string tag, input logic [1:0] f, input logic [7:0] v);
    chk({tag, "_editing"}, 32'(editing), 32'd1);
    chk({tag, "_field"},   32'(field),   32'(f));
    chk({tag, "_val"},     32'(edit_val), 32'(v));
  endtask

  // Called in the first cycle after the mode press that enters COMMIT.
  // Cycles 1..8: setup/strobe pairs for mil, hour, min, sec; cycle 9: done.
  task automatic run_commit(input logic [7:0] m, input logic [7:0] h,
                            input logic [7:0] mi, input logic [7:0] s, input bit noise);
    logic [7:0] v [4];
    v[0] = m; v[1] = h; v[2] = mi; v[3] = s;
    for (int k = 1; k <= 8; k++) begin
      int f;
      f = (k - 1) / 2;
      chk("commit_time_in", 32'(time_in), 32'(v[f]));
      chk("commit_strobe",  32'(strb), (k % 2 == 0) ? 32'(4'b1000 >> f) : 32'd0);
      chk("commit_done",    32'(done), 32'd0);
      chk("commit_editing", 32'(editing), 32'd0);
      if (noise && k == 2) btn_mode   = 1'b1;
      if (noise && k == 5) btn_cancel = 1'b1;
      if (noise && k == 6) btn_inc    = 1'b1;
      tick();
      btn_mode = 1'b0; btn_cancel = 1'b0; btn_inc = 1'b0;
    end
    chk("commit_done_pulse", 32'(done), 32'd1);
    chk("commit_end_strobe", 32'(strb), 32'd0);
    chk("commit_end_bus",    32'(time_in), 32'd0);
    tick();
    chk("commit_done_low",   32'(done), 32'd0);
    chk("commit_idle",       32'(editing), 32'd0);
  endtask

  initial begin
    int seen;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
    time_cur = 32'h0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // Reset values, before any clock edge.
    chk("rst_time_in", 32'(time_in), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_editing", 32'(editing), 32'd0);
    chk("rst_field",   32'(field), 32'd0);
    chk("rst_editval", 32'(edit_val), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Buttons other than mode are ignored in IDLE.
    time_cur = 32'h010C1E2D;
    press(0, 1, 0, 0);
    chk("idle_inc_ignored", 32'(editing), 32'd0);
    press(0, 0, 1, 1);
    chk("idle_dec_cancel_ignored", 32'(editing), 32'd0);

    // Basic commit with no edits.
    press(1, 0, 0, 0); chk_edit("basic_mil",  2'd0, 8'h01);
    press(1, 0, 0, 0); chk_edit("basic_hour", 2'd1, 8'h0C);
    press(1, 0, 0, 0); chk_edit("basic_min",  2'd2, 8'h1E);
    press(1, 0, 0, 0); chk_edit("basic_sec",  2'd3, 8'h2D);
    press(1, 0, 0, 0);
    run_commit(8'h01, 8'h0C, 8'h1E, 8'h2D, 1'b0);

    // Wrap cases, then cancel.
    time_cur = 32'h01170005;
    press(1, 0, 0, 0); chk_edit("wrap_mil_load", 2'd0, 8'd1);
    press(0, 1, 0, 0); chk_edit("wrap_mil_inc",  2'd0, 8'd0);
    press(1, 0, 0, 0); chk_edit("wrap_hour_load", 2'd1, 8'd23);
    press(0, 1, 0, 0); chk_edit("wrap_hour_inc", 2'd1, 8'd0);
    press(0, 0, 1, 0); chk_edit("wrap_hour_dec", 2'd1, 8'd23);
    press(1, 0, 0, 0); chk_edit("wrap_min_load", 2'd2, 8'd0);
    press(0, 0, 1, 0); chk_edit("wrap_min_dec",  2'd2, 8'd59);
    press(0, 1, 0, 0); chk_edit("cancel_min_inc", 2'd2, 8'd0);
    press(0, 1, 0, 1);
    chk("cancel_editing",  32'(editing), 32'd0);
    chk("cancel_field",    32'(field), 32'd0);
    chk("cancel_edit_val", 32'(edit_val), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (strb != 4'd0 || done) seen++;
      tick();
    end
    chk("cancel_no_strobes", 32'(seen), 32'd0);

    // Clamp on load and button priority; commit with button noise.
    time_cur = 32'h05303C3B;
    press(1, 0, 0, 0); chk_edit("clamp_mil", 2'd0, 8'd0);
    press(0, 1, 1, 0); chk_edit("incdec_same_cycle", 2'd0, 8'd0);
    press(1, 1, 0, 0); chk_edit("clamp_hour_mode_inc", 2'd1, 8'd0);
    press(0, 1, 0, 0); chk_edit("hour_inc", 2'd1, 8'd1);
    press(1, 0, 1, 0); chk_edit("clamp_min_mode_dec", 2'd2, 8'd0);
    press(1, 0, 0, 0); chk_edit("sec_load", 2'd3, 8'd59);
    press(0, 1, 1, 0); chk_edit("sec_incdec", 2'd3, 8'd59);
    press(1, 0, 0, 0);
    run_commit(8'd0, 8'd1, 8'd0, 8'd59, 1'b1);

    // Reset during the set_hour strobe cycle.
    time_cur = 32'h00050607;
    repeat (5) press(1, 0, 0, 0);
    repeat (3) tick();
    chk("midrst_hour_strobe", 32'(strb), 32'b0100);
    chk("midrst_hour_bus",    32'(time_in), 32'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_strobe_drop", 32'(strb), 32'd0);
    chk("midrst_bus_zero",    32'(time_in), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (strb != 4'd0 || done || editing) seen++;
      tick();
    end
    chk("midrst_no_more_strobes", 32'(seen), 32'd0);

    // First button is honoured on the first edge after reset release.
    #2 rst_n = 1'b0;
    #2;
    time_cur = 32'h01020304;
    rst_n    = 1'b1;
    press(1, 0, 0, 0);
    chk_edit("post_rst_mode", 2'd0, 8'd1);
    press(0, 0, 0, 1);
    chk("post_rst_cancel", 32'(editing), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
